// File: rtl/mixer_pkg.sv
// Shared constants and types for the I/Q mixer scheduler and its fixed-point multiplier.
package mixer_pkg;

   localparam int DATA_WIDTH      = 32;
   localparam int DATA_FRAC_WIDTH = 23;
   localparam int CNT_WIDTH       = 16;

   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef logic chan_t;

endpackage

// File: rtl/mixer.sv
// Combinational fixed-point multiplier (Q8.23 at default width) with overflow/underflow flags.
module mixer #(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_FRAC_WIDTH = 23
) (
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [DATA_WIDTH-1:0] out,
   output logic                         overflow,
   output logic                         underflow
);

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [2*DATA_WIDTH-1:0] scaled;
   logic        [DATA_WIDTH:0]     upper;

   assign prod   = a * b;
   assign scaled = prod >>> DATA_FRAC_WIDTH;
   // Result fits only when everything above the output MSB is a copy of the sign.
   assign upper  = scaled[2*DATA_WIDTH-1:DATA_WIDTH-1];

   assign out       = scaled[DATA_WIDTH-1:0];
   assign overflow  = !prod[2*DATA_WIDTH-1] && (|upper);
   assign underflow = prod[2*DATA_WIDTH-1] && !(&upper);

endmodule

// File: rtl/mixer_scheduler.sv
// Round-robin share of one mixer between the I and Q channels, with a registered
// saturating result slot and clip event counters.
module mixer_scheduler #(
   parameter int DATA_WIDTH      = mixer_pkg::DATA_WIDTH,
   parameter int DATA_FRAC_WIDTH = mixer_pkg::DATA_FRAC_WIDTH,
   parameter int CNT_WIDTH       = mixer_pkg::CNT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [1:0][DATA_WIDTH-1:0] req_a,
   input  logic [1:0][DATA_WIDTH-1:0] req_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_chan,
   output logic                       out_clip,
   input  logic                       cnt_clear,
   output logic [CNT_WIDTH-1:0]       ovf_count,
   output logic [CNT_WIDTH-1:0]       unf_count
);

   import mixer_pkg::*;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   localparam logic [DATA_WIDTH-1:0] SAT_HI = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_LO = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [0:0]            slot_state;
   chan_t                 last_grant;
   chan_t                 grant;
   logic                  slot_free;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] mix_a;
   logic [DATA_WIDTH-1:0] mix_b;
   logic [DATA_WIDTH-1:0] mix_out;
   logic                  mix_ovf;
   logic                  mix_unf;
   logic                  clip_ovf;
   logic                  clip_unf;
   logic [DATA_WIDTH-1:0] sat_data;
   logic                  sat_clip;

   assign out_valid = (slot_state == ST_FULL);

   // The channel that did not win last time is preferred; a lone requester always wins.
   always_comb begin
      slot_free = !out_valid || out_ready;
      grant     = ~last_grant;
      if (!req_valid[~last_grant]) begin
         grant = last_grant;
      end
      req_ready = '0;
      if (!rst && slot_free && (|req_valid)) begin
         req_ready[grant] = 1'b1;
      end
      xfer = |(req_valid & req_ready);
   end

   assign mix_a = req_a[grant];
   assign mix_b = req_b[grant];

   mixer #(
      .DATA_WIDTH      (DATA_WIDTH),
      .DATA_FRAC_WIDTH (DATA_FRAC_WIDTH)
   ) u_mixer (
      .a         (mix_a),
      .b         (mix_b),
      .out       (mix_out),
      .overflow  (mix_ovf),
      .underflow (mix_unf)
   );

   // Overflow takes precedence if the mixer ever raises both flags.
   always_comb begin
      clip_ovf = mix_ovf;
      clip_unf = mix_unf && !mix_ovf;
      sat_data = mix_out;
      sat_clip = 1'b0;
      if (clip_ovf) begin
         sat_data = SAT_HI;
         sat_clip = 1'b1;
      end else if (clip_unf) begin
         sat_data = SAT_LO;
         sat_clip = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_state <= ST_EMPTY;
         out_data   <= '0;
         out_chan   <= 1'b0;
         out_clip   <= 1'b0;
         last_grant <= 1'b1;
      end else if (xfer) begin
         slot_state <= ST_FULL;
         out_data   <= sat_data;
         out_chan   <= grant;
         out_clip   <= sat_clip;
         last_grant <= grant;
      end else if (out_ready) begin
         slot_state <= ST_EMPTY;
      end
   end

   // Clip counters stick at all-ones; a clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || cnt_clear) begin
         ovf_count <= '0;
         unf_count <= '0;
      end else if (xfer) begin
         if (clip_ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
         end
         if (clip_unf && (unf_count != '1)) begin
            unf_count <= unf_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mixer_scheduler.sv
// Randomized scoreboard bench for mixer_scheduler against a behavioural arbitration/product model.
module tb_mixer_scheduler;

   import mixer_pkg::*;

   localparam int W  = 32;
   localparam int F  = 23;
   localparam int CW = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][W-1:0] req_a;
   logic [1:0][W-1:0] req_b;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic             out_chan;
   logic             out_clip;
   logic             cnt_clear;
   logic [CW-1:0]    ovf_count;
   logic [CW-1:0]    unf_count;

   mixer_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_clip  (out_clip),
      .cnt_clear (cnt_clear),
      .ovf_count (ovf_count),
      .unf_count (unf_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         chan;
      logic [W-1:0] data;
      bit         clip;
      int         kind;   // 0 none, 1 overflow, 2 underflow
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   // Behavioural model state: who won last, whether a result is held, clip tallies.
   bit   m_last = 1'b1;
   bit   m_full = 1'b0;
   int   m_ovf  = 0;
   int   m_unf  = 0;

   bit           pend[2];
   logic [W-1:0] pa[2];
   logic [W-1:0] pb[2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Exact product, scaled by 2^-F, then clamped into the signed output range.
   function automatic exp_t ref_mix(input bit ch, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint p;
      longint q;
      longint hi;
      longint lo;
      hi = 64'sd2147483647;
      lo = -hi - 1;
      p  = longint'($signed(a)) * longint'($signed(b));
      q  = p >>> F;
      e.chan = ch;
      if (q > hi) begin
         e.data = SAT_MAX; e.clip = 1'b1; e.kind = 1;
      end else if (q < lo) begin
         e.data = SAT_MIN; e.clip = 1'b1; e.kind = 2;
      end else begin
         e.data = q[W-1:0]; e.clip = 1'b0; e.kind = 0;
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic signed [W-1:0] s;
      case ($urandom_range(3))
         0: return $urandom();
         1: begin
            s = $signed($urandom());
            return s >>> 6;
         end
         2: return ($urandom_range(1) == 1) ? (32'h7FFF0000 | ($urandom() & 32'hFFFF))
                                            : (32'h80000000 | ($urandom() & 32'hFFFF));
         default: return 32'h00800000 + $urandom_range(16);
      endcase
   endfunction

   task automatic offer(input int ch, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!pend[ch]) begin
         pend[ch] = 1'b1;
         pa[ch]   = a;
         pb[ch]   = b;
      end
   endtask

   // One clock: drive, predict and check the handshake, queue the expected result.
   task automatic cycle(input bit ordy, input bit clr, input bit rs);
      int   g;
      bit   pref;
      exp_t e;
      logic [1:0] exp_rdy;
      req_valid = {pend[1], pend[0]};
      req_a[0]  = pa[0];
      req_b[0]  = pb[0];
      req_a[1]  = pa[1];
      req_b[1]  = pb[1];
      out_ready = ordy;
      cnt_clear = clr;
      rst       = rs;
      @(negedge clk);
      check("out_valid", out_valid, m_full);
      check("ovf_count", ovf_count, m_ovf);
      check("unf_count", unf_count, m_unf);
      g = 2;
      if (!rs && (!m_full || ordy)) begin
         pref = !m_last;
         if (pend[pref]) g = pref;
         else if (pend[m_last]) g = m_last;
      end
      exp_rdy = (g < 2) ? (2'b01 << g) : 2'b00;
      check("req_ready", req_ready, exp_rdy);
      if (rs) begin
         m_full = 1'b0;
         m_last = 1'b1;
         m_ovf  = 0;
         m_unf  = 0;
         sb_q.delete();
      end else begin
         if (g < 2) begin
            e = ref_mix(g[0], pa[g], pb[g]);
            sb_q.push_back(e);
            pend[g] = 1'b0;
            m_last  = g[0];
            m_full  = 1'b1;
         end else if (ordy) begin
            m_full = 1'b0;
         end
         if (clr) begin
            m_ovf = 0;
            m_unf = 0;
         end else if (g < 2) begin
            if (e.kind == 1 && m_ovf < 65535) m_ovf++;
            if (e.kind == 2 && m_unf < 65535) m_unf++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (m_full || pend[0] || pend[1]); i++) cycle(1'b1, 1'b0, 1'b0);
      check("drain_timeout", {m_full, pend[0], pend[1]}, 3'b000);
   endtask

   // Monitor: pop one expectation per presented result and hold it while stalled.
   bit   have_cur = 1'b0;
   exp_t cur;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            have_cur = 1'b0;
         end else if (out_valid === 1'b1) begin
            if (!have_cur) begin
               if (sb_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_result: got data %0h chan %0d with nothing expected", out_data, out_chan);
               end else begin
                  cur      = sb_q.pop_front();
                  have_cur = 1'b1;
               end
            end
            if (have_cur) begin
               check("out_chan", out_chan, cur.chan);
               check("out_data", out_data, cur.data);
               check("out_clip", out_clip, cur.clip);
               if (out_ready) have_cur = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pend[0] = 1'b0; pend[1] = 1'b0;
      pa[0] = '0; pb[0] = '0; pa[1] = '0; pb[1] = '0;
      rst = 1'b1;
      req_valid = 2'b11;
      req_a = '0;
      req_b = '0;
      out_ready = 1'b1;
      cnt_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_chan", out_chan, 1'b0);
      check("rst_out_clip", out_clip, 1'b0);
      check("rst_ovf_count", ovf_count, 16'h0);
      check("rst_unf_count", unf_count, 16'h0);

      // Directed products and clip accounting.
      offer(0, 32'h01000000, 32'h00800000);
      cycle(1'b1, 1'b0, 1'b0);
      check("plain_data", out_data, 32'h01000000);
      check("plain_chan", out_chan, 1'b0);
      check("plain_clip", out_clip, 1'b0);
      offer(1, 32'h7FFFFFFF, 32'h00800001);
      cycle(1'b1, 1'b0, 1'b0);
      check("ovf_data", out_data, 32'h7FFFFFFF);
      check("ovf_chan", out_chan, 1'b1);
      check("ovf_clip", out_clip, 1'b1);
      check("ovf_cnt1", ovf_count, 16'd1);
      offer(0, 32'h80000000, 32'h00800001);
      cycle(1'b1, 1'b0, 1'b0);
      check("unf_data", out_data, 32'h80000000);
      check("unf_clip", out_clip, 1'b1);
      check("unf_cnt1", unf_count, 16'd1);
      offer(0, 32'h80000000, 32'h00800001);
      cycle(1'b1, 1'b1, 1'b0);
      check("clear_wins", unf_count, 16'd0);
      drain();

      // Fairness: last winner was ch0, so ch1 leads and the channels alternate.
      for (int i = 0; i < 8; i++) begin
         offer(0, rand_op(), rand_op());
         offer(1, rand_op(), rand_op());
         cycle(1'b1, 1'b0, 1'b0);
         check("fair_valid", out_valid, 1'b1);
         check("fair_chan", out_chan, (i + 1) % 2);
      end

      // Backpressure: stalled slot blocks both requesters; then full rate resumes.
      offer(0, rand_op(), rand_op());
      offer(1, rand_op(), rand_op());
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         offer(0, rand_op(), rand_op());
         offer(1, rand_op(), rand_op());
         cycle(1'b1, 1'b0, 1'b0);
      end
      drain();

      // Random traffic with random stalls and occasional counter clears.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) != 0) offer(0, rand_op(), rand_op());
         if ($urandom_range(3) != 0) offer(1, rand_op(), rand_op());
         cycle($urandom_range(3) != 0, $urandom_range(63) == 0, 1'b0);
      end
      drain();

      // Reset with a full slot and three overflows counted.
      cycle(1'b1, 1'b1, 1'b0);
      offer(0, 32'h7FFFFFFF, 32'h00800001);
      offer(1, 32'h7FFFFFFF, 32'h00800001);
      for (int i = 0; i < 4 && (pend[0] || pend[1]); i++) cycle(1'b1, 1'b0, 1'b0);
      offer(0, 32'h7FFFFFFF, 32'h00800001);
      cycle(1'b1, 1'b0, 1'b0);
      check("pre_rst_ovf", ovf_count, 16'd3);
      check("pre_rst_full", out_valid, 1'b1);
      offer(0, 32'h00400000, 32'h00800000);
      offer(1, 32'h00C00000, 32'h00800000);
      cycle(1'b0, 1'b0, 1'b1);
      check("post_rst_valid", out_valid, 1'b0);
      check("post_rst_ovf", ovf_count, 16'd0);
      check("post_rst_unf", unf_count, 16'd0);
      check("post_rst_data", out_data, 32'h0);
      cycle(1'b1, 1'b0, 1'b0);
      check("post_rst_first_chan", out_chan, 1'b0);
      check("post_rst_first_data", out_data, 32'h00400000);
      drain();
      cycle(1'b1, 1'b0, 1'b0);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
